// File: rtl/snes_pad_emulator_if.sv
// Pad-side bundle for the SNES device emulator: host lines, button source and frame status.
// The host/stimulus side drives latch, clock and buttons; the emulator drives everything else.
interface snes_pad_emulator_if;
  logic [11:0] buttons;
  logic        pad_latch;
  logic        pad_clock;
  logic        pad_data;
  logic        busy;
  logic        frame_done;
  logic [4:0]  bit_count;

  modport master (
    output buttons, pad_latch, pad_clock,
    input  pad_data, busy, frame_done, bit_count
  );

  modport slave (
    input  buttons, pad_latch, pad_clock,
    output pad_data, busy, frame_done, bit_count
  );
endinterface

// File: rtl/snes_pad_emulator.sv
// Device side of the SNES serial pad protocol: answers host latch/clock with 16 active-low bits.
//   state | meaning
//   IDLE  | no frame in progress, pad_data held high
//   LATCH | latch high, shift register reloaded from buttons every cycle
//   SHIFT | shifting one bit per synchronised pad_clock rising edge
//   DONE  | all 16 bits sent, pad_data low until the next latch
module snes_pad_emulator #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 4096,
  parameter logic [3:0] ID_BITS     = 4'b0000
) (
  input  logic          clock,
  input  logic          reset,
  snes_pad_emulator_if.slave pad
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LATCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int         TW    = $clog2(TIMEOUT);

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   latch_d;
  logic                   clk_d;
  logic [1:0]             state;
  logic [15:0]            shreg;
  logic [4:0]             bit_count;
  logic                   frame_done;
  logic [TW-1:0]          timer;

  logic        latch_s;
  logic        clk_s;
  logic        latch_rise;
  logic        latch_fall;
  logic        clk_rise;
  logic [15:0] load_value;

  // pad_clock idles high, so its synchroniser resets high to avoid a false edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latch_sync <= '0;
      clk_sync   <= '1;
      latch_d    <= 1'b0;
      clk_d      <= 1'b1;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.pad_latch};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], pad.pad_clock};
      latch_d    <= latch_sync[SYNC_STAGES-1];
      clk_d      <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_d;
  assign latch_fall = ~latch_s & latch_d;
  assign clk_rise   = clk_s & ~clk_d;
  assign load_value = ~{ID_BITS, pad.buttons};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= 16'hFFFF;
      bit_count  <= 5'd0;
      frame_done <= 1'b0;
      timer      <= '0;
    end else begin
      frame_done <= 1'b0;
      // A latch edge wins over everything, including a coincident clock edge.
      if (latch_rise) begin
        state     <= LATCH;
        shreg     <= load_value;
        bit_count <= 5'd0;
      end else begin
        case (state)
          LATCH: begin
            shreg     <= load_value;
            bit_count <= 5'd0;
            if (latch_fall) begin
              state <= SHIFT;
              timer <= TW'(TIMEOUT - 1);
            end
          end
          SHIFT: begin
            if (clk_rise) begin
              shreg     <= {1'b0, shreg[15:1]};
              bit_count <= bit_count + 5'd1;
              timer     <= TW'(TIMEOUT - 1);
              if (bit_count == 5'd15) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end
            end else if (timer == '0) begin
              state     <= IDLE;
              shreg     <= 16'hFFFF;
              bit_count <= 5'd0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign pad.pad_data   = shreg[0];
  assign pad.busy       = (state == LATCH) || (state == SHIFT);
  assign pad.frame_done = frame_done;
  assign pad.bit_count  = bit_count;
endmodule

// File: tb/tb_snes_pad_emulator.sv
// Bench for snes_pad_emulator: a host model drives latch/clock, samples on falling edges and
// checks two devices (standard ID and ID 4'b0101) against a scoreboard of expected wire bits.
module tb_snes_pad_emulator;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 4096;
  localparam int HALF    = 30;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        latch = 1'b0;
  logic        pclk  = 1'b1;
  logic [11:0] btn   = 12'h000;

  int n_checks = 0;
  int n_fail   = 0;
  int fd0      = 0;
  int fd1      = 0;

  logic [1:0] sb[$];

  snes_pad_emulator_if pif0();
  snes_pad_emulator_if pif1();

  assign pif0.pad_latch = latch;
  assign pif0.pad_clock = pclk;
  assign pif0.buttons   = btn;
  assign pif1.pad_latch = latch;
  assign pif1.pad_clock = pclk;
  assign pif1.buttons   = btn;

  snes_pad_emulator #(.SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT), .ID_BITS(4'b0000)) dut0 (
    .clock(clock), .reset(rst), .pad(pif0));
  snes_pad_emulator #(.SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT), .ID_BITS(4'b0101)) dut1 (
    .clock(clock), .reset(rst), .pad(pif1));

  always #50 clock = ~clock;

  always @(negedge clock) begin
    if (pif0.frame_done === 1'b1) fd0++;
    if (pif1.frame_done === 1'b1) fd1++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    wait_cyc(120);
    latch = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic push_frame();
    logic [15:0] e0, e1;
    e0 = ~{4'b0000, btn};
    e1 = ~{4'b0101, btn};
    for (int i = 0; i < 16; i++) sb.push_back({e1[i], e0[i]});
  endtask

  task automatic clock_pulses(input int n, output logic [15:0] w0, output logic [15:0] w1);
    logic [1:0] e;
    w0 = 16'hFFFF;
    w1 = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      pclk = 1'b0;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty bit %0d: no expected value queued", k);
      end else begin
        e = sb.pop_front();
        w0[k] = pif0.pad_data;
        w1[k] = pif1.pad_data;
        if (pif0.pad_data !== e[0] || pif1.pad_data !== e[1]) begin
          n_fail++;
          $display("FAIL serial_bit %0d: got dut0=%b dut1=%b expected dut0=%b dut1=%b",
                   k, pif0.pad_data, pif1.pad_data, e[0], e[1]);
        end
      end
      wait_cyc(HALF);
      pclk = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  task automatic test_reset();
    logic [15:0] w0, w1;
    int fd_before;
    wait_cyc(3);
    n_checks++;
    if (pif0.pad_data !== 1'b1 || pif0.busy !== 1'b0 || pif0.bit_count !== 5'd0 || pif0.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got data=%b busy=%b cnt=%0d fd=%b expected 1 0 0 0",
               pif0.pad_data, pif0.busy, pif0.bit_count, pif0.frame_done);
    end
    rst = 1'b0;
    wait_cyc(5);
    btn = 12'h155;
    latch_pulse();
    push_frame();
    clock_pulses(5, w0, w1);
    n_checks++;
    if (pif0.bit_count !== 5'd5 || pif0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_shift: got cnt=%0d busy=%b expected 5 1", pif0.bit_count, pif0.busy);
    end
    fd_before = fd0;
    #20 rst = 1'b1;
    #1;
    n_checks++;
    if (pif0.pad_data !== 1'b1 || pif0.busy !== 1'b0 || pif0.bit_count !== 5'd0 || pif0.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got data=%b busy=%b cnt=%0d fd=%b expected 1 0 0 0",
               pif0.pad_data, pif0.busy, pif0.bit_count, pif0.frame_done);
    end
    sb.delete();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    for (int k = 0; k < 3; k++) begin
      pclk = 1'b0; wait_cyc(10); pclk = 1'b1; wait_cyc(10);
    end
    n_checks++;
    if (pif0.bit_count !== 5'd0 || pif0.busy !== 1'b0 || pif0.pad_data !== 1'b1 || fd0 !== fd_before) begin
      n_fail++;
      $display("FAIL post_reset_idle: got cnt=%0d busy=%b data=%b fd=%0d expected 0 0 1 %0d",
               pif0.bit_count, pif0.busy, pif0.pad_data, fd0, fd_before);
    end
  endtask

  task automatic test_standard_frame();
    logic [15:0] w0, w1;
    int fd_before;
    btn = 12'h001;
    fd_before = fd0;
    latch_pulse();
    push_frame();
    clock_pulses(16, w0, w1);
    wait_cyc(5);
    n_checks++;
    if (w0 !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL standard_word: got %h expected fffe", w0);
    end
    n_checks++;
    if (fd0 - fd_before !== 1) begin
      n_fail++;
      $display("FAIL standard_frame_done: got %0d pulses expected 1", fd0 - fd_before);
    end
    n_checks++;
    if (pif0.pad_data !== 1'b0 || pif0.bit_count !== 5'd16 || pif0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL standard_done: got data=%b cnt=%0d busy=%b expected 0 16 0",
               pif0.pad_data, pif0.bit_count, pif0.busy);
    end
  endtask

  task automatic test_mixed_buttons();
    logic [15:0] w0, w1;
    int fd_before;
    btn = 12'hA5A;
    fd_before = fd1;
    latch_pulse();
    push_frame();
    btn = 12'h3C3;
    clock_pulses(16, w0, w1);
    wait_cyc(5);
    n_checks++;
    if (~w1 !== 16'h5A5A || w1[12] !== 1'b0 || w1[14] !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed_id_word: got state=%h expected 5a5a", ~w1);
    end
    n_checks++;
    if (~w0 !== 16'h0A5A) begin
      n_fail++;
      $display("FAIL mixed_std_word: got state=%h expected 0a5a", ~w0);
    end
    n_checks++;
    if (fd1 - fd_before !== 1) begin
      n_fail++;
      $display("FAIL mixed_frame_done: got %0d pulses expected 1", fd1 - fd_before);
    end
  endtask

  task automatic test_live_latch();
    logic [15:0] w0, w1;
    latch = 1'b1;
    wait_cyc(SYNC + 3);
    for (int k = 0; k < 4; k++) begin
      btn[0] = k[0];
      wait_cyc(SYNC + 2);
      n_checks++;
      if (pif0.pad_data !== ~btn[0]) begin
        n_fail++;
        $display("FAIL live_latch %0d: got data=%b expected %b", k, pif0.pad_data, ~btn[0]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      pclk = 1'b0; wait_cyc(10); pclk = 1'b1; wait_cyc(10);
    end
    n_checks++;
    if (pif0.bit_count !== 5'd0 || pif0.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL latch_ignores_clock: got cnt=%0d busy=%b expected 0 1", pif0.bit_count, pif0.busy);
    end
    btn = 12'h881;
    wait_cyc(5);
    latch = 1'b0;
    wait_cyc(HALF);
    push_frame();
    clock_pulses(16, w0, w1);
  endtask

  task automatic test_timeout_abort();
    logic [15:0] w0, w1;
    int fd_before;
    btn = 12'h0C3;
    fd_before = fd0;
    latch_pulse();
    push_frame();
    clock_pulses(7, w0, w1);
    sb.delete();
    wait_cyc(TIMEOUT - 200);
    n_checks++;
    if (pif0.busy !== 1'b1 || pif0.bit_count !== 5'd7) begin
      n_fail++;
      $display("FAIL timeout_early: got busy=%b cnt=%0d expected 1 7", pif0.busy, pif0.bit_count);
    end
    wait_cyc(400);
    n_checks++;
    if (pif0.busy !== 1'b0 || pif0.pad_data !== 1'b1 || pif0.bit_count !== 5'd0 || fd0 !== fd_before) begin
      n_fail++;
      $display("FAIL timeout_idle: got busy=%b data=%b cnt=%0d fd=%0d expected 0 1 0 %0d",
               pif0.busy, pif0.pad_data, pif0.bit_count, fd0, fd_before);
    end
    btn = 12'h3C5;
    latch_pulse();
    push_frame();
    clock_pulses(7, w0, w1);
    sb.delete();
    btn = 12'h90E;
    latch_pulse();
    push_frame();
    clock_pulses(16, w0, w1);
    wait_cyc(5);
    n_checks++;
    if (~w0 !== 16'h090E || fd0 - fd_before !== 1 || pif0.bit_count !== 5'd16) begin
      n_fail++;
      $display("FAIL abort_restart: got state=%h fd=%0d cnt=%0d expected 090e 1 16",
               ~w0, fd0 - fd_before, pif0.bit_count);
    end
  endtask

  task automatic test_coincident();
    logic [15:0] w0, w1;
    btn = 12'h0F1;
    latch_pulse();
    push_frame();
    clock_pulses(3, w0, w1);
    sb.delete();
    pclk = 1'b0;
    wait_cyc(HALF);
    latch = 1'b1;
    pclk  = 1'b1;
    wait_cyc(SYNC + 3);
    n_checks++;
    if (pif0.busy !== 1'b1 || pif0.bit_count !== 5'd0 || pif0.pad_data !== 1'b0) begin
      n_fail++;
      $display("FAIL coincident_edges: got busy=%b cnt=%0d data=%b expected 1 0 0",
               pif0.busy, pif0.bit_count, pif0.pad_data);
    end
    wait_cyc(50);
    latch = 1'b0;
    wait_cyc(HALF);
    push_frame();
    clock_pulses(16, w0, w1);
    n_checks++;
    if (~w0 !== 16'h00F1) begin
      n_fail++;
      $display("FAIL coincident_frame: got state=%h expected 00f1", ~w0);
    end
  endtask

  initial begin
    test_reset();
    test_standard_frame();
    test_mixed_buttons();
    test_live_latch();
    test_timeout_abort();
    test_coincident();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snes_pad_emulator.md
Name: snes_pad_emulator

Overview:
- Device side of the SNES serial pad protocol: the FPGA acts as a controller for an external SNES console or SNES-protocol host.
- Samples asynchronous latch and clock lines from the host and shifts out 16 active-low button bits on the data line.
- Button state comes from internal logic, e.g. a keyboard mapper or a replay buffer.
- Sits beside the pad reader; shares bit order and polarity so the two can be looped back for self-test.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on pad_latch and pad_clock; legal range 2..4.
- TIMEOUT, 4096: clock cycles without a pad_clock rising edge in SHIFT before the frame is abandoned.
- ID_BITS, 4'b0000: pressed-sense value of bits 12..15. 0 drives the line high, as on a standard pad.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- buttons  in  12  active-high pressed. Bit order: 0 B, 1 Y, 2 SELECT, 3 START, 4 UP, 5 DOWN, 6 LEFT, 7 RIGHT, 8 A, 9 X, 10 L, 11 R.
- pad_latch  in  1  latch from host, asynchronous to clock.
- pad_clock  in  1  serial clock from host, idles high, asynchronous to clock.
- pad_data  out  1  serial data to host; 0 = pressed.
- busy  out  1  high in LATCH or SHIFT.
- frame_done  out  1  one-cycle pulse when the 16th bit has been shifted out.
- bit_count  out  5  number of bits shifted in the current frame, 0..16.

Behaviour:
- Reset (async assert, sync release): state IDLE, pad_data=1, busy=0, frame_done=0, bit_count=0, shift register=16'hFFFF.
- Synchronisation: pad_latch and pad_clock each pass through SYNC_STAGES flops. One extra flop per line feeds edge detection. All decisions use only the synchronised values.
- Latency: an input edge acts within SYNC_STAGES+1 clock cycles.
- Shift register: 16 bits, wire-level sense, loaded as ~{ID_BITS, buttons}. Bit 0 is B. pad_data is always shift register bit 0.
- IDLE:
  - pad_data=1.
  - Synchronised latch rising edge -> LATCH.
- LATCH:
  - Reload the shift register every cycle, so pad_data tracks ~buttons[0] live. bit_count=0.
  - Clock edges are ignored while latch is high.
  - Latch falling edge -> SHIFT. The register is frozen with the last loaded value.
- SHIFT:
  - On each synchronised pad_clock rising edge: shift right, fill bit 15 with 0, increment bit_count, clear the timeout counter.
  - bit_count reaching 16 -> DONE and assert frame_done in that same cycle.
  - Timeout counter reaching TIMEOUT-1 -> IDLE, pad_data=1, no frame_done.
- DONE:
  - pad_data=0, matching a real pad after 16 clocks.
  - Stays until the next latch rising edge -> LATCH.
- Latch priority: a latch rising edge in any state goes to LATCH and aborts any partial frame. If a latch rising edge and a clock rising edge occur in the same cycle, latch wins and the clock edge is dropped.
- Pad_clock falling edges have no effect; the host samples on its own falling edge.
- buttons changing during SHIFT does not affect the current frame.
- Asynchronous reset mid-frame returns to the reset values immediately; the next frame needs a fresh latch.
- bit_count saturates at 16 in DONE and clears on entry to LATCH or IDLE.

Test Plan:
- Reset then idle: assert reset mid-SHIFT at bit 5 -> pad_data=1, busy=0, bit_count=0 with no clock edge needed; no frame_done.
- Standard frame: buttons=12'h001 (B), 12 us latch pulse, then 16 pad_clock pulses at 6 us period with the host sampling on falling edges -> host reads 0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1. frame_done pulses once; pad_data=0 afterwards.
- Mixed buttons: buttons=12'hA5A with ID_BITS=4'b0101 -> sampled word 16'h5A5A read LSB first, with bit 12 and bit 14 low. Loopback into the pad reader gives button_state=16'h5A5A.
- Live latch: hold latch high, toggle buttons[0] -> pad_data follows ~buttons[0] within SYNC_STAGES+2 cycles. Pad_clock pulses during latch leave bit_count=0.
- Timeout and abort: after a latch, give 7 clocks and then silence -> IDLE after TIMEOUT cycles with pad_data=1. In a separate run, a new latch at bit 7 restarts the frame and a full 16 bits follow correctly.
- Coincident edges: drive latch and clock rising in the same clock cycle -> state LATCH, bit_count=0, and the shift register is not advanced.
